// File: rtl/mem_pkg.sv
// Shared memory-side definitions: line geometry and the line_memory FSM states.
// The data cache controller imports this package for its line width as well.
package mem_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/line_ram.sv
// Synchronous single-port line array with a write enable and a registered read port.
// The read register holds its value until the next read.
module line_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [IDX_W-1:0]     addr_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    // Array write; the storage itself is never reset.
    // NOTE: memories get no reset branch -- a reset loop over DEPTH entries would
    // stop the array from mapping onto RAM and would wipe preloaded contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Registered read data; only the output register is cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/line_memory.sv
// Backing line memory for the data cache: accepts one 256-bit read or write
// through the enable/write/ack handshake and completes it after LATENCY cycles.
module line_memory
    import mem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 busy_o,
    output logic [31:0]          rd_count_o,
    output logic [31:0]          wr_count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 wr_q;
    logic [LINE_BITS-1:0] line_q;
    logic [31:0]          rd_cnt_q, wr_cnt_q;
    logic                 accept, commit;
    logic                 ram_we, ram_re;

    // Offset bits and bits above the line index are ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the accept/commit strobes for this cycle.
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT;
                    accept  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latency counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(LATENCY - 1);
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Request capture; later input changes cannot affect an accepted request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q  <= '0;
            wr_q   <= 1'b0;
            line_q <= '0;
        end else if (accept) begin
            idx_q  <= addr_i[OFFSET_BITS +: IDX_W];
            wr_q   <= write_i;
            line_q <= data_i;
        end
    end

    // Completion statistics, bumped on the commit edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (commit) begin
            if (wr_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign ram_we = commit &  wr_q;
    assign ram_re = commit & ~wr_q;

    line_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (idx_q),
        .wdata_i (line_q),
        .rdata_o (data_o)
    );

    assign ack_o      = (state_q == ACK);
    assign busy_o     = (state_q != IDLE);
    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: table-driven transactions plus hand-written
// sequences for perturbation, back-to-back and reset-mid-write cases.
module tb_line_memory;

    localparam int DEPTH   = 512;
    localparam int LATENCY = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;
    logic [31:0]  rd_count_o, wr_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    line_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .enable_i   (enable_i),
        .write_i    (write_i),
        .ack_o      (ack_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .rd_count_o (rd_count_o),
        .wr_count_o (wr_count_o)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [255:0] exp_data;
        logic [31:0]  exp_rd;
        logic [31:0]  exp_wr;
    } vec_t;

    localparam logic [255:0] PAT_A5  = {32{8'hA5}};
    localparam logic [255:0] PAT_1   = {8{32'h1234_5678}};
    localparam logic [255:0] PAT_2   = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT_3   = {8{32'h0F1E_2D3C}};
    localparam logic [255:0] PAT_4   = {8{32'h5555_AAAA}};
    localparam logic [255:0] PAT_6   = {16{16'h6666}};
    localparam logic [255:0] PAT_TOP = {16{16'hC0DE}};
    localparam logic [255:0] PAT_OLD = {8{32'h0BAD_F00D}};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request; perturb_at > 0 scrambles the inputs after that many
    // edges past acceptance. lat returns the negedge index of the ack (0 = none).
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                           input int perturb_at, output int lat);
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = d;
        @(posedge clk_i);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk_i);
            if (k == 1) check("busy_after_accept", 256'(busy_o), 256'(1'b1));
            if (k == perturb_at) begin
                addr_i   = addr ^ 32'h0000_0060;
                write_i  = ~wr;
                enable_i = 1'b0;
                data_i   = '1;
            end
            if (ack_o) begin
                enable_i = 1'b0;
                lat = k;
                break;
            end
        end
        check("ack_latency", 256'(lat), 256'(LATENCY + 1));
        @(negedge clk_i);
        check("ack_single_pulse", 256'(ack_o), 256'(1'b0));
    endtask

    vec_t vecs [6];
    int   lat;
    int   acks;
    int   ack_at [2];

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0060, '0,    PAT_A5,  32'd1, 32'd0};
        vecs[1] = '{1'b1, 32'h0000_0400, PAT_1, PAT_A5,  32'd1, 32'd1};
        vecs[2] = '{1'b0, 32'h0000_041C, '0,    PAT_1,   32'd2, 32'd1};
        vecs[3] = '{1'b1, 32'h4000_0060, PAT_2, PAT_1,   32'd2, 32'd2};
        vecs[4] = '{1'b0, 32'h0000_0060, '0,    PAT_2,   32'd3, 32'd2};
        vecs[5] = '{1'b0, 32'h0000_3FE0, '0,    PAT_TOP, 32'd4, 32'd2};

        u_dut.u_ram.mem[3]   = PAT_A5;
        u_dut.u_ram.mem[5]   = PAT_OLD;
        u_dut.u_ram.mem[6]   = PAT_6;
        u_dut.u_ram.mem[32]  = PAT_OLD;
        u_dut.u_ram.mem[511] = PAT_TOP;

        // Reset then idle.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_ack",  256'(ack_o),      256'(1'b0));
        check("rst_busy", 256'(busy_o),     256'(1'b0));
        check("rst_data", data_o,           '0);
        check("rst_rd",   256'(rd_count_o), '0);
        check("rst_wr",   256'(wr_count_o), '0);
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (ack_o || busy_o) acks++;
        end
        check("idle_no_activity", 256'(acks), '0);

        // Table-driven transactions.
        for (int v = 0; v < 6; v++) begin
            run_req(vecs[v].wr, vecs[v].addr, vecs[v].data, 0, lat);
            check($sformatf("vec%0d_data", v), data_o,           vecs[v].exp_data);
            check($sformatf("vec%0d_rd",   v), 256'(rd_count_o), 256'(vecs[v].exp_rd));
            check($sformatf("vec%0d_wr",   v), 256'(wr_count_o), 256'(vecs[v].exp_wr));
        end

        // Input perturbation: write line 5, then point inputs at line 6 as a read.
        run_req(1'b1, 32'h0000_00A0, PAT_3, 3, lat);
        check("perturb_wr", 256'(wr_count_o), 256'(32'd3));
        check("perturb_rd", 256'(rd_count_o), 256'(32'd4));
        run_req(1'b0, 32'h0000_00A0, '0, 0, lat);
        check("perturb_line5", data_o, PAT_3);
        run_req(1'b0, 32'h0000_00C0, '0, 0, lat);
        check("perturb_line6", data_o, PAT_6);

        // Back-to-back: enable held through the first ack.
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h0000_0060;
        @(posedge clk_i);
        acks = 0;
        ack_at[0] = 0;
        ack_at[1] = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_i);
            if (ack_o) begin
                if (acks < 2) ack_at[acks] = k;
                acks++;
                if (acks == 2) enable_i = 1'b0;
            end
        end
        check("b2b_ack_count",  256'(acks),      256'(2));
        check("b2b_first_ack",  256'(ack_at[0]), 256'(LATENCY + 1));
        check("b2b_second_ack", 256'(ack_at[1]), 256'(2 * LATENCY + 3));
        check("b2b_data",       data_o,          PAT_2);
        check("b2b_rd",         256'(rd_count_o), 256'(32'd8));

        // Reset in the middle of a write to line 32.
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_0400;
        data_i   = PAT_4;
        @(posedge clk_i);
        acks = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        rst_i    = 1'b0;
        enable_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        rst_i = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        check("rstmid_no_ack", 256'(acks),       '0);
        check("rstmid_wr",     256'(wr_count_o), '0);
        check("rstmid_rd",     256'(rd_count_o), '0);
        run_req(1'b0, 32'h0000_0400, '0, 0, lat);
        check("rstmid_old_data", data_o,           PAT_1);
        check("rstmid_rd_after", 256'(rd_count_o), 256'(32'd1));
        check("rstmid_wr_after", 256'(wr_count_o), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
